// File: rtl/clk_step_pkg.sv
// clk_step_pkg
//   Shared definitions for the front-panel clock/step controller:
//   default timing constants and the sequencer state encoding.
package clk_step_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000;
  localparam int unsigned RESET_CYCLES_DEF    = 16;
  localparam int unsigned CNT_W_DEF           = 16;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_HALT  = 2'd1,
    S_RUN   = 2'd2,
    S_STEP  = 2'd3
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Synchronises one asynchronous, bouncy button line and debounces it.
//   The debounced level only changes after DEBOUNCE_CYCLES consecutive
//   cycles in which the synchronised input disagrees with it. A rising
//   change of the debounced level produces a one-cycle press pulse.
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   raw_in in   raw button line, asynchronous to clk
//   level  out  debounced level
//   press  out  one-cycle pulse on debounced rising edge
module btn_debounce
  import clk_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count mismatching cycles; the DEBOUNCE_CYCLES-th one flips the level
  // and clears the counter, so it never exceeds CNT_LAST.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl
//   Front-panel controller for the TTL CPU sim. Debounces the RUN, STEP
//   and RESET buttons, stretches the CPU reset, and sequences the CPU
//   clock enable through HALT / RUN / single-STEP modes (Moore outputs).
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   run_in     in   RUN button, asynchronous, bouncy
//   step_in    in   STEP button, asynchronous, bouncy
//   reset_in   in   RESET button, asynchronous, bouncy
//   cpu_halt   in   CPU executed HALT (level, synchronous)
//   cpu_clk_en out  CPU advances one cycle when high
//   cpu_rst    out  CPU reset, active-high
//   running    out  high while in RUN mode
module clk_step_ctrl
  import clk_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned RESET_CYCLES    = RESET_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run_in,
  input  logic step_in,
  input  logic reset_in,
  input  logic cpu_halt,
  output logic cpu_clk_en,
  output logic cpu_rst,
  output logic running
);

  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_CYCLES - 1);

  logic run_press, step_press, reset_press;
  logic run_level_unused, step_level_unused, reset_level_unused;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_run_db (
    .clk   (clk),
    .rst   (rst),
    .raw_in(run_in),
    .level (run_level_unused),
    .press (run_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_step_db (
    .clk   (clk),
    .rst   (rst),
    .raw_in(step_in),
    .level (step_level_unused),
    .press (step_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_reset_db (
    .clk   (clk),
    .rst   (rst),
    .raw_in(reset_in),
    .level (reset_level_unused),
    .press (reset_press)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;

  // RESET button overrides everything, including an ongoing stretch.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    if (reset_press) begin
      state_d   = S_RESET;
      rst_cnt_d = RST_LOAD;
    end else begin
      case (state_q)
        S_RESET: begin
          if (rst_cnt_q == '0) state_d = S_HALT;
          else                 rst_cnt_d = rst_cnt_q - 1'b1;
        end
        S_HALT: begin
          if (run_press)       state_d = S_RUN;
          else if (step_press) state_d = S_STEP;
        end
        S_STEP: state_d = S_HALT;
        S_RUN: begin
          if (run_press || cpu_halt) state_d = S_HALT;
        end
        default: begin
          state_d   = S_RESET;
          rst_cnt_d = RST_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RESET;
      rst_cnt_q <= RST_LOAD;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  assign cpu_rst    = (state_q == S_RESET);
  assign cpu_clk_en = (state_q == S_RUN) || (state_q == S_STEP);
  assign running    = (state_q == S_RUN);

endmodule

// File: tb/tb_clk_step_ctrl.sv
// tb_clk_step_ctrl
//   Directed bench for clk_step_ctrl with DEBOUNCE_CYCLES=4, RESET_CYCLES=3.
//   Outputs are compared as {cpu_rst, cpu_clk_en, running} on the falling
//   edge; inputs change on the falling edge. A second instance with a long
//   reset stretch shows that a RESET press during the stretch restarts it.
module tb_clk_step_ctrl;

  localparam logic [2:0] O_RST  = 3'b100;
  localparam logic [2:0] O_HALT = 3'b000;
  localparam logic [2:0] O_RUN  = 3'b011;
  localparam logic [2:0] O_STEP = 3'b010;

  localparam int unsigned B_RUN   = 0;
  localparam int unsigned B_STEP  = 1;
  localparam int unsigned B_RESET = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic       cpu_halt;
  logic       cpu_clk_en, cpu_rst, running;
  logic       l_reset_in;
  logic       l_clk_en, l_rst, l_running;
  logic [2:0] outs, louts;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  clk_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RESET_CYCLES   (3),
    .CNT_W          (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run_in    (btn[B_RUN]),
    .step_in   (btn[B_STEP]),
    .reset_in  (btn[B_RESET]),
    .cpu_halt  (cpu_halt),
    .cpu_clk_en(cpu_clk_en),
    .cpu_rst   (cpu_rst),
    .running   (running)
  );

  clk_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RESET_CYCLES   (12),
    .CNT_W          (8)
  ) dut_long (
    .clk       (clk),
    .rst       (rst),
    .run_in    (1'b0),
    .step_in   (1'b0),
    .reset_in  (l_reset_in),
    .cpu_halt  (1'b0),
    .cpu_clk_en(l_clk_en),
    .cpu_rst   (l_rst),
    .running   (l_running)
  );

  assign outs  = {cpu_rst, cpu_clk_en, running};
  assign louts = {l_rst, l_clk_en, l_running};

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n clock cycles, checking the main instance after each.
  task automatic watch(input string tag, input int n, input logic [2:0] exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, outs, exp);
    end
  endtask

  task automatic watch_l(input string tag, input int n, input logic [2:0] exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, louts, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    btn        = '0;
    cpu_halt   = 1'b0;
    l_reset_in = 1'b0;

    // 1: reset stretch after rst
    @(negedge clk);
    rst = 1'b0;
    check("rst_c1", outs, O_RST);
    watch("rst_hold", 2, O_RST);
    watch("rst_done", 1, O_HALT);

    // 2: bouncing STEP, then stable press -> single step pulse
    for (int i = 0; i < 10; i++) begin
      btn[B_STEP] = (i % 2 == 0);
      watch("step_bounce", 1, O_HALT);
    end
    btn[B_STEP] = 1'b1;
    watch("step_wait", 6, O_HALT);
    watch("step_pulse", 1, O_STEP);
    watch("step_after", 1, O_HALT);
    btn[B_STEP] = 1'b0;
    watch("step_rel", 8, O_HALT);

    // 3: RUN, then cpu_halt stops it; held RUN gives no second press
    btn[B_RUN] = 1'b1;
    watch("run_wait", 6, O_HALT);
    watch("run_on", 3, O_RUN);
    cpu_halt = 1'b1;
    watch("halt_stop", 1, O_HALT);
    cpu_halt = 1'b0;
    watch("run_held", 8, O_HALT);
    btn[B_RUN] = 1'b0;
    watch("run_rel", 8, O_HALT);

    // 3b: STEP allowed from HALT while cpu_halt is high
    cpu_halt    = 1'b1;
    btn[B_STEP] = 1'b1;
    watch("hstep_wait", 6, O_HALT);
    watch("hstep_pulse", 1, O_STEP);
    watch("hstep_after", 1, O_HALT);
    btn[B_STEP] = 1'b0;
    watch("hstep_rel", 8, O_HALT);
    cpu_halt = 1'b0;

    // 4: STEP ignored in RUN; second RUN press halts; held RUN no re-toggle
    btn[B_RUN] = 1'b1;
    watch("run2_wait", 6, O_HALT);
    watch("run2_on", 1, O_RUN);
    btn[B_RUN] = 1'b0;
    btn[B_STEP] = 1'b1;
    watch("step_ign", 8, O_RUN);
    btn[B_STEP] = 1'b0;
    watch("step_ign_rel", 8, O_RUN);
    btn[B_RUN] = 1'b1;
    watch("run_tog_wait", 6, O_RUN);
    watch("run_off", 1, O_HALT);
    watch("run_held2", 8, O_HALT);
    btn[B_RUN] = 1'b0;
    watch("run_rel2", 8, O_HALT);

    // 5: simultaneous RUN/STEP/RESET -> reset wins
    btn = 3'b111;
    watch("sim_wait", 6, O_HALT);
    watch("sim_rst", 3, O_RST);
    watch("sim_halt", 4, O_HALT);
    btn = '0;
    watch("sim_rel", 8, O_HALT);

    // 6a: RESET press while running
    btn[B_RUN] = 1'b1;
    watch("run3_wait", 6, O_HALT);
    watch("run3_on", 1, O_RUN);
    btn[B_RUN] = 1'b0;
    watch("run3_hold", 8, O_RUN);
    btn[B_RESET] = 1'b1;
    watch("rstp_wait", 6, O_RUN);
    watch("rstp_hold", 3, O_RST);
    watch("rstp_done", 1, O_HALT);
    btn[B_RESET] = 1'b0;
    watch("rstp_rel", 8, O_HALT);

    // 6b: second RESET press during a 12-cycle stretch restarts it
    l_reset_in = 1'b1;
    watch_l("l_idle", 4, O_HALT);
    l_reset_in = 1'b0;
    watch_l("l_idle2", 2, O_HALT);
    watch_l("l_first", 2, O_RST);
    l_reset_in = 1'b1;
    watch_l("l_restart", 18, O_RST);
    watch_l("l_done", 1, O_HALT);
    l_reset_in = 1'b0;
    watch_l("l_rel", 8, O_HALT);

    // 6c: rst while running -> reset values next cycle
    btn[B_RUN] = 1'b1;
    watch("run4_wait", 6, O_HALT);
    watch("run4_on", 1, O_RUN);
    btn[B_RUN] = 1'b0;
    watch("run4_hold", 2, O_RUN);
    rst = 1'b1;
    watch("rst_run", 1, O_RST);
    rst = 1'b0;
    watch("rst_run_hold", 2, O_RST);
    watch("rst_run_done", 1, O_HALT);
    watch("rst_run_quiet", 8, O_HALT);

    // 6d: rst in the middle of a button-triggered stretch restarts it
    btn[B_RESET] = 1'b1;
    watch("ms_wait", 4, O_HALT);
    btn[B_RESET] = 1'b0;
    watch("ms_wait2", 2, O_HALT);
    watch("ms_c1", 1, O_RST);
    rst = 1'b1;
    watch("ms_rst", 1, O_RST);
    rst = 1'b0;
    watch("ms_hold", 2, O_RST);
    watch("ms_done", 1, O_HALT);
    watch("ms_quiet", 8, O_HALT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
